// File: rtl/cdc_fifo_gray_src_mc_if.sv
// Bundle between a multi-channel CDC FIFO source half and its neighbours:
// the upstream valid/ready streams, the fill/almost-full status, and the
// asynchronous storage / gray pointer signals exchanged with the destination half.
interface cdc_fifo_gray_src_mc_if #(
  parameter int unsigned NumChan   = 5,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LogDepth  = 2
);

  logic [NumChan-1:0][DataWidth-1:0]                src_data_i;
  logic [NumChan-1:0]                               src_valid_i;
  logic [NumChan-1:0]                               src_ready_o;
  logic [NumChan-1:0][LogDepth:0]                   src_fill_o;
  logic [NumChan-1:0]                               src_almost_full_o;
  logic [NumChan-1:0][(2**LogDepth)-1:0][DataWidth-1:0] async_data_o;
  logic [NumChan-1:0][LogDepth:0]                   async_wptr_o;
  logic [NumChan-1:0][LogDepth:0]                   async_rptr_i;

  // Upstream producer plus destination half, as seen from outside the FIFO.
  modport master (
    output src_data_i, src_valid_i, async_rptr_i,
    input  src_ready_o, src_fill_o, src_almost_full_o, async_data_o, async_wptr_o
  );

  // The FIFO source half itself.
  modport slave (
    input  src_data_i, src_valid_i, async_rptr_i,
    output src_ready_o, src_fill_o, src_almost_full_o, async_data_o, async_wptr_o
  );

endinterface

// File: rtl/cdc_fifo_gray_src_mc.sv
// Multi-channel source half of a gray-pointer CDC FIFO. Each channel owns a
// 2**LogDepth-entry storage array, a binary/gray write pointer pair and a
// SyncStages-deep synchronizer on the incoming gray read pointer. Channels
// share nothing but the clock and reset.
module cdc_fifo_gray_src_mc #(
  parameter int unsigned NumChan          = 5,
  parameter int unsigned DataWidth        = 32,
  parameter int unsigned LogDepth         = 2,
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned AlmostFullThresh = (2 ** LogDepth) - 1
) (
  input  logic                  src_clk_i,
  input  logic                  src_rst_i,
  cdc_fifo_gray_src_mc_if.slave bus_if
);

  localparam int unsigned Depth = 2 ** LogDepth;
  localparam int          PtrW  = LogDepth + 1;

  // Binary to reflected-gray conversion.
  function automatic logic [PtrW-1:0] bin_to_gray(input logic [PtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected-gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PtrW-1:0] gray_to_bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] b;
    b = g;
    for (int i = 1; i < PtrW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  logic [NumChan-1:0][PtrW-1:0]               wptr_b_q, wptr_b_d;
  logic [NumChan-1:0][PtrW-1:0]               wptr_g_q, wptr_g_d;
  logic [NumChan-1:0][PtrW-1:0]               sync_q [SyncStages];
  logic [NumChan-1:0][Depth-1:0][DataWidth-1:0] mem_q;

  logic [NumChan-1:0][PtrW-1:0]               rptr_b_s;
  logic [NumChan-1:0][PtrW-1:0]               fill_s;
  logic [NumChan-1:0]                         full_s;
  logic [NumChan-1:0]                         ready_s;
  logic [NumChan-1:0]                         afull_s;
  logic [NumChan-1:0]                         write_s;

  // Occupancy, full/almost-full and handshake from the local write pointer and the synchronized read pointer.
  always_comb begin
    rptr_b_s = '0;
    fill_s   = '0;
    full_s   = '0;
    ready_s  = '0;
    afull_s  = '0;
    write_s  = '0;
    for (int ch = 0; ch < NumChan; ch++) begin
      rptr_b_s[ch] = gray_to_bin(sync_q[SyncStages-1][ch]);
      // Modular subtraction on LogDepth+1 bits keeps fill correct across pointer rollover.
      fill_s[ch]   = wptr_b_q[ch] - rptr_b_s[ch];
      full_s[ch]   = (fill_s[ch] == PtrW'(Depth));
      ready_s[ch]  = ~full_s[ch] & ~src_rst_i;
      afull_s[ch]  = (fill_s[ch] >= PtrW'(AlmostFullThresh));
      write_s[ch]  = bus_if.src_valid_i[ch] & ready_s[ch];
    end
  end

  // Next write pointers: advance both binary and gray forms on an accepted beat.
  always_comb begin
    wptr_b_d = wptr_b_q;
    wptr_g_d = wptr_g_q;
    for (int ch = 0; ch < NumChan; ch++) begin
      if (write_s[ch]) begin
        wptr_b_d[ch] = wptr_b_q[ch] + PtrW'(1);
        wptr_g_d[ch] = bin_to_gray(wptr_b_d[ch]);
      end else begin
        wptr_b_d[ch] = wptr_b_q[ch];
        wptr_g_d[ch] = wptr_g_q[ch];
      end
    end
  end

  // Write pointer registers; the gray copy feeds the destination domain directly from a flop.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      wptr_b_q <= '0;
      wptr_g_q <= '0;
    end else begin
      wptr_b_q <= wptr_b_d;
      wptr_g_q <= wptr_g_d;
    end
  end

  // Read-pointer synchronizer chain; only gray values cross, so at most one bit is in flight.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= bus_if.async_rptr_i;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Storage write; a slot is only written while the channel is not full, so unread data is never overwritten.
  always_ff @(posedge src_clk_i) begin
    if (src_rst_i) begin
      mem_q <= '0;
    end else begin
      for (int ch = 0; ch < NumChan; ch++) begin
        if (write_s[ch]) begin
          mem_q[ch][wptr_b_q[ch][LogDepth-1:0]] <= bus_if.src_data_i[ch];
        end
      end
    end
  end

  assign bus_if.src_ready_o       = ready_s;
  assign bus_if.src_fill_o        = fill_s;
  assign bus_if.src_almost_full_o = afull_s;
  assign bus_if.async_data_o      = mem_q;
  assign bus_if.async_wptr_o      = wptr_g_q;

endmodule
